// File: rtl/lfsr_step_ctrl_pkg.sv
// lfsr_step_ctrl_pkg: shared state encodings and default constants for the LFSR step controller
package lfsr_step_ctrl_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int DEF_WIDTH = 8;
  localparam logic [DEF_WIDTH-1:0] DEF_SEED = 8'h1D;
  localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 8'h1D;
endpackage

// File: rtl/lfsr_step_ctrl_debounce.sv
// lfsr_step_ctrl_debounce: 2-flop sync, stability counter and registered press pulse
module lfsr_step_ctrl_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        rise  <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/lfsr_step_ctrl.sv
// lfsr_step_ctrl: debounced step/run/load sequencer for an LFSR or rotate register
module lfsr_step_ctrl
  import lfsr_step_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SEED = DEF_SEED,
  parameter logic [WIDTH-1:0] TAPS = DEF_TAPS,
  parameter int DB_CYCLES = 16,
  parameter int RUN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             btn_load,
  input  logic [WIDTH-1:0] sw_seed,
  input  logic             mode_lfsr,
  output logic [WIDTH-1:0] q,
  output logic [15:0]      step_cnt,
  output logic             running,
  output logic             step_pulse
);
  localparam int DW = $clog2(RUN_DIV);
  state_t state;
  logic [DW-1:0] div;
  logic ev_step, ev_run, ev_load, do_step;
  logic [WIDTH-1:0] nxt;
  lfsr_step_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (.clk(clk), .rst(rst), .btn(btn_step), .rise(ev_step));
  lfsr_step_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run  (.clk(clk), .rst(rst), .btn(btn_run),  .rise(ev_run));
  lfsr_step_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (.clk(clk), .rst(rst), .btn(btn_load), .rise(ev_load));
  always_comb begin
    nxt     = mode_lfsr ? {^(q & TAPS), q[WIDTH-1:1]} : {q[0], q[WIDTH-1:1]};
    do_step = (state == ST_IDLE) ? ev_step : (div == DW'(RUN_DIV - 1));
  end
  assign running = (state == ST_RUN);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      div        <= '0;
      q          <= SEED;
      step_cnt   <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (ev_load) begin
        q        <= (sw_seed == '0 && mode_lfsr) ? SEED : sw_seed;
        step_cnt <= '0;
        state    <= ST_IDLE;
        div      <= '0;
      end else if (ev_run) begin
        state <= (state == ST_IDLE) ? ST_RUN : ST_IDLE;
        div   <= '0;
      end else if (do_step) begin
        q          <= nxt;
        step_cnt   <= step_cnt + 16'd1;
        step_pulse <= 1'b1;
        div        <= '0;
      end else if (state == ST_RUN) div <= div + 1'b1;
    end
  end
endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// tb_lfsr_step_ctrl: randomized self-checking bench against an arithmetic reference model
module tb_lfsr_step_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_step = 1'b0, btn_run = 1'b0, btn_load = 1'b0;
  logic [7:0] sw_seed = 8'h00;
  logic mode_lfsr = 1'b1;
  logic [7:0] q;
  logic [15:0] step_cnt;
  logic running, step_pulse;
  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  logic [7:0] m_q;
  int m_cnt;
  lfsr_step_ctrl #(.DB_CYCLES(4), .RUN_DIV(8)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .btn_run(btn_run), .btn_load(btn_load),
    .sw_seed(sw_seed), .mode_lfsr(mode_lfsr), .q(q), .step_cnt(step_cnt),
    .running(running), .step_pulse(step_pulse)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst && step_pulse) pulses++;
  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end
  function automatic logic [7:0] ref_step(input logic [7:0] v, input logic lfsr);
    int x, fb;
    x  = int'(v);
    fb = $countones(v & 8'h1D) % 2;
    return 8'(lfsr ? fb * 128 + x / 2 : (x % 2) * 128 + x / 2);
  endfunction
  task automatic press(input int which, input int hold);
    @(negedge clk);
    if (which == 0) btn_step = 1'b1; else if (which == 1) btn_run = 1'b1; else btn_load = 1'b1;
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    btn_run  = 1'b0;
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    m_q = 8'h1D;
    m_cnt = 0;
    pulses = 0;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (q !== 8'h1D || step_cnt !== 16'd0 || running !== 1'b0 || step_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: q=%h cnt=%0d run=%b pulse=%b, want q=1d cnt=0 run=0 pulse=0", q, step_cnt, running, step_pulse);
    end
    m_q = 8'h1D;
    m_cnt = 0;
  endtask
  task automatic test_step_modes();
    do_reset();
    mode_lfsr = 1'b1;
    press(0, 10);
    vectors++;
    if (q !== 8'h0E || step_cnt !== 16'd1 || pulses !== 1) begin
      miscompares++;
      $display("FAIL step_lfsr: q=%h cnt=%0d pulses=%0d, want q=0e cnt=1 pulses=1", q, step_cnt, pulses);
    end
    do_reset();
    mode_lfsr = 1'b0;
    press(0, 10);
    vectors++;
    if (q !== 8'h8E || step_cnt !== 16'd1 || pulses !== 1) begin
      miscompares++;
      $display("FAIL step_rotate: q=%h cnt=%0d pulses=%0d, want q=8e cnt=1 pulses=1", q, step_cnt, pulses);
    end
  endtask
  task automatic test_bounce();
    do_reset();
    mode_lfsr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btn_step = (i % 2 == 0);
    end
    repeat (20) @(negedge clk);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (pulses !== 1 || q !== 8'h0E || step_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL bounce: pulses=%0d q=%h cnt=%0d, want pulses=1 q=0e cnt=1", pulses, q, step_cnt);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      int op;
      int p0;
      op = $urandom_range(0, 3);
      mode_lfsr = 1'($urandom_range(0, 1));
      p0 = pulses;
      if (op == 3) begin
        sw_seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        press(2, 8 + $urandom_range(0, 6));
        m_q = (sw_seed == 8'h00 && mode_lfsr) ? 8'h1D : sw_seed;
        m_cnt = 0;
      end else begin
        press(0, 8 + $urandom_range(0, 6));
        m_q = ref_step(m_q, mode_lfsr);
        m_cnt = (m_cnt + 1) % 65536;
      end
      vectors++;
      if (q !== m_q || step_cnt !== 16'(m_cnt) || pulses - p0 !== (op == 3 ? 0 : 1) || running !== 1'b0) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d: q=%h cnt=%0d pulses=%0d run=%b, want q=%h cnt=%0d pulses=%0d run=0",
                 i, op, q, step_cnt, pulses - p0, running, m_q, m_cnt, (op == 3 ? 0 : 1));
      end
    end
  endtask
  task automatic test_run();
    logic [7:0] q0, qf;
    int c0, pf;
    do_reset();
    mode_lfsr = 1'($urandom_range(0, 1));
    q0 = q;
    c0 = int'(step_cnt);
    pulses = 0;
    press(1, 10);
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL run_enter: running=%b, want 1", running);
    end
    for (int k = 0; k < 4; k++) begin
      int cyc;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!step_pulse && cyc < 20);
      if (k > 0) begin
        vectors++;
        if (cyc !== 8) begin
          miscompares++;
          $display("FAIL run_period[%0d]: gap=%0d cycles, want 8", k, cyc);
        end
      end
    end
    press(1, 10);
    m_q = q0;
    for (int i = 0; i < pulses; i++) m_q = ref_step(m_q, mode_lfsr);
    m_cnt = c0 + pulses;
    vectors++;
    if (running !== 1'b0 || q !== m_q || step_cnt !== 16'(m_cnt) || pulses < 4) begin
      miscompares++;
      $display("FAIL run_stop: run=%b q=%h cnt=%0d pulses=%0d, want run=0 q=%h cnt=%0d pulses>=4",
               running, q, step_cnt, pulses, m_q, m_cnt);
    end
    qf = q;
    pf = pulses;
    repeat (30) @(negedge clk);
    vectors++;
    if (q !== qf || pulses !== pf) begin
      miscompares++;
      $display("FAIL run_frozen: q=%h extra_pulses=%0d, want q=%h extra_pulses=0", q, pulses - pf, qf);
    end
  endtask
  task automatic test_load_in_run();
    do_reset();
    press(1, 10);
    repeat (10) @(negedge clk);
    sw_seed = 8'h00;
    mode_lfsr = 1'b1;
    press(2, 10);
    vectors++;
    if (q !== 8'h1D || step_cnt !== 16'd0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL load_zero_run: q=%h cnt=%0d run=%b, want q=1d cnt=0 run=0", q, step_cnt, running);
    end
    sw_seed = 8'hA5;
    mode_lfsr = 1'($urandom_range(0, 1));
    press(2, 10);
    vectors++;
    if (q !== 8'hA5 || step_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL load_a5: q=%h cnt=%0d, want q=a5 cnt=0", q, step_cnt);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force dut.step_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.step_cnt;
    @(negedge clk);
    vectors++;
    if (step_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_preload: cnt=%h, want ffff", step_cnt);
    end
    press(0, 10);
    vectors++;
    if (step_cnt !== 16'h0000 || pulses !== 1) begin
      miscompares++;
      $display("FAIL wrap: cnt=%h pulses=%0d, want cnt=0000 pulses=1", step_cnt, pulses);
    end
  endtask
  task automatic test_reset_mid_run();
    do_reset();
    press(1, 10);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if (q !== 8'h1D || step_cnt !== 16'd0 || running !== 1'b0 || step_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run: q=%h cnt=%0d run=%b pulse=%b, want q=1d cnt=0 run=0 pulse=0", q, step_cnt, running, step_pulse);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (25) @(negedge clk);
    vectors++;
    if (q !== 8'h1D || pulses !== 0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: q=%h pulses=%0d run=%b, want q=1d pulses=0 run=0", q, pulses, running);
    end
  endtask
  initial begin
    test_reset();
    test_step_modes();
    test_bounce();
    test_random();
    test_run();
    test_load_in_run();
    test_wrap();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
